spi_reg_target: RTL and testbench



---
 rtl/spi_reg_target.sv | 176 +++++++++++++++++
 tb/tb_spi_reg_target.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_target.sv
// SPI mode-0 target exposing 2**ADDR_W 8-bit registers; SPI pins are oversampled in the clk domain.
// Define SPI_REG_TARGET_READ_EN to build the read (MISO) path; otherwise read commands are sunk.
module spi_reg_target #(
   parameter int unsigned ADDR_W    = 3,
   parameter logic [7:0]  RESET_VAL = 8'h00
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sclk_i,
   input  logic                     csn_i,
   input  logic                     mosi_i,
   output logic                     miso_o,
   output logic                     miso_oe_o,
   output logic [8*(2**ADDR_W)-1:0] regs_o,
   output logic                     wr_stb_o,
   output logic [ADDR_W-1:0]        wr_addr_o
);
   localparam int unsigned REGS_W = 8 * (2**ADDR_W);

`ifdef SPI_REG_TARGET_READ_EN
   typedef enum logic [1:0] {StIdle, StCmd, StWr, StRd} state_e;
`else
   typedef enum logic [1:0] {StIdle, StCmd, StWr, StSink} state_e;
`endif

   logic              r_sclk_s1, r_sclk_s2, r_sclk_s3;
   logic              r_csn_s1, r_csn_s2, r_csn_s3;
   logic              r_mosi_s1, r_mosi_s2;
   state_e            r_state, w_state_d;
   logic [2:0]        r_bit_cnt, w_bit_cnt_d;
   logic [6:0]        r_shift_in, w_shift_in_d;
   logic [ADDR_W-1:0] r_ptr, w_ptr_d;
   logic [REGS_W-1:0] r_regs, w_regs_d;
   logic              r_wr_stb, w_wr_stb_d;
   logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_d;
   logic              w_sclk_rise, w_csn_fall, w_csn_rise, w_byte_done;
   logic [7:0]        w_byte;
`ifdef SPI_REG_TARGET_READ_EN
   logic              w_sclk_fall;
   logic [7:0]        r_shift_out, w_shift_out_d;
   logic              r_load_pend, w_load_pend_d;
`endif

   // Two synchronizer stages, third stage for edge detection on sclk/csn.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {r_sclk_s1, r_sclk_s2, r_sclk_s3} <= 3'b000;
         {r_csn_s1, r_csn_s2, r_csn_s3}    <= 3'b111;
         {r_mosi_s1, r_mosi_s2}            <= 2'b00;
      end else begin
         {r_sclk_s1, r_sclk_s2, r_sclk_s3} <= {sclk_i, r_sclk_s1, r_sclk_s2};
         {r_csn_s1, r_csn_s2, r_csn_s3}    <= {csn_i, r_csn_s1, r_csn_s2};
         {r_mosi_s1, r_mosi_s2}            <= {mosi_i, r_mosi_s1};
      end
   end

   assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
   assign w_csn_fall  = ~r_csn_s2 & r_csn_s3;
   assign w_csn_rise  = r_csn_s2 & ~r_csn_s3;
`ifdef SPI_REG_TARGET_READ_EN
   assign w_sclk_fall = ~r_sclk_s2 & r_sclk_s3;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= StIdle;
         r_bit_cnt  <= '0;
         r_shift_in <= '0;
         r_ptr      <= '0;
         r_regs     <= {(2**ADDR_W){RESET_VAL}};
         r_wr_stb   <= 1'b0;
         r_wr_addr  <= '0;
`ifdef SPI_REG_TARGET_READ_EN
         r_shift_out <= '0;
         r_load_pend <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_d;
         r_bit_cnt  <= w_bit_cnt_d;
         r_shift_in <= w_shift_in_d;
         r_ptr      <= w_ptr_d;
         r_regs     <= w_regs_d;
         r_wr_stb   <= w_wr_stb_d;
         r_wr_addr  <= w_wr_addr_d;
`ifdef SPI_REG_TARGET_READ_EN
         r_shift_out <= w_shift_out_d;
         r_load_pend <= w_load_pend_d;
`endif
      end
   end

   always_comb begin
      w_state_d    = r_state;
      w_bit_cnt_d  = r_bit_cnt;
      w_shift_in_d = r_shift_in;
      w_ptr_d      = r_ptr;
      w_regs_d     = r_regs;
      w_wr_stb_d   = 1'b0;
      w_wr_addr_d  = r_wr_addr;
`ifdef SPI_REG_TARGET_READ_EN
      w_shift_out_d = r_shift_out;
      w_load_pend_d = r_load_pend;
`endif
      w_byte      = {r_shift_in, r_mosi_s2};
      w_byte_done = 1'b0;

      if (r_state != StIdle && w_sclk_rise) begin
         w_shift_in_d = w_byte[6:0];
         w_bit_cnt_d  = r_bit_cnt + 3'd1;
         w_byte_done  = (r_bit_cnt == 3'd7);
      end

      if (w_byte_done) begin
         unique case (r_state)
            StCmd: begin
               w_ptr_d = w_byte[ADDR_W-1:0];
`ifdef SPI_REG_TARGET_READ_EN
               w_state_d     = w_byte[7] ? StRd : StWr;
               w_load_pend_d = w_byte[7];
`else
               w_state_d = w_byte[7] ? StSink : StWr;
`endif
            end
            StWr: begin
               w_regs_d[{r_ptr, 3'b000} +: 8] = w_byte;
               w_wr_stb_d  = 1'b1;
               w_wr_addr_d = r_ptr;
               w_ptr_d     = r_ptr + ADDR_W'(1);
            end
`ifdef SPI_REG_TARGET_READ_EN
            StRd: w_load_pend_d = 1'b1;
`endif
            default: ;
         endcase
      end

`ifdef SPI_REG_TARGET_READ_EN
      // The first falling edge after a byte boundary loads the next register.
      if (r_state == StRd && w_sclk_fall) begin
         if (r_load_pend) begin
            w_shift_out_d = r_regs[{r_ptr, 3'b000} +: 8];
            w_ptr_d       = r_ptr + ADDR_W'(1);
            w_load_pend_d = 1'b0;
         end else begin
            w_shift_out_d = {r_shift_out[6:0], 1'b0};
         end
      end
`endif

      // A byte completing together with csn rise is still written above.
      if (r_state == StIdle) begin
         if (w_csn_fall) begin
            w_state_d   = StCmd;
            w_bit_cnt_d = '0;
         end
      end else if (w_csn_rise) begin
         w_state_d   = StIdle;
         w_bit_cnt_d = '0;
`ifdef SPI_REG_TARGET_READ_EN
         w_load_pend_d = 1'b0;
`endif
      end
   end

   assign regs_o    = r_regs;
   assign wr_stb_o  = r_wr_stb;
   assign wr_addr_o = r_wr_addr;
`ifdef SPI_REG_TARGET_READ_EN
   assign miso_o    = (r_state == StRd) & r_shift_out[7];
   assign miso_oe_o = ~r_csn_s2;
`else
   assign miso_o    = 1'b0;
   assign miso_oe_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_target.sv
// Bench for spi_reg_target: an SPI master drives random frames; a reference register array
// predicts strobes (scoreboarded by a monitor), register contents and read data.
module tb_spi_reg_target;
   localparam int unsigned NREG = 8;
   localparam logic [7:0]  RV   = 8'h00;

   logic        clk = 1'b0;
   logic        rst, sclk, csn, mosi;
   logic        miso, miso_oe, wr_stb;
   logic [63:0] regs;
   logic [2:0]  wr_addr;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  m_regs [NREG];
   time         t_rise = 0;

   typedef struct {
      logic [2:0]  addr;
      logic [63:0] regs;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   spi_reg_target #(.ADDR_W(3), .RESET_VAL(RV)) dut (
      .clk       (clk),
      .rst       (rst),
      .sclk_i    (sclk),
      .csn_i     (csn),
      .mosi_i    (mosi),
      .miso_o    (miso),
      .miso_oe_o (miso_oe),
      .regs_o    (regs),
      .wr_stb_o  (wr_stb),
      .wr_addr_o (wr_addr)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [63:0] model_vec();
      logic [63:0] v;
      for (int i = 0; i < NREG; i++) v[8*i +: 8] = m_regs[i];
      return v;
   endfunction

   // Monitor: every strobe must match the oldest predicted write.
   always @(negedge clk) begin
      if (wr_stb === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_strobe: got strobe addr %0d, expected none at %0t",
                     wr_addr, $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", {61'd0, wr_addr}, {61'd0, mon_e.addr});
            check("regs_at_strobe", regs, mon_e.regs);
            check("strobe_latency", 64'($time - t_rise), 64'd30);
         end
      end
   end

   task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
      rx = '0;
      for (int i = 7; i > 7 - nb; i--) begin
         mosi = tx[i];
         #50;
         rx[i] = miso;
         sclk   = 1'b1;
         t_rise = $time;
         #50;
         sclk = 1'b0;
      end
   endtask

   task automatic frame_begin();
      csn = 1'b0;
      #60;
   endtask

   task automatic frame_end();
      #60;
      csn = 1'b1;
      #100;
   endtask

   task automatic end_check();
      check("pending_strobes", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      check("regs_after_frame", regs, model_vec());
   endtask

   task automatic write_frame(input logic [7:0] cmd, input logic [7:0] data[$]);
      logic [7:0] rx;
      int         a;
      a = int'(cmd[2:0]);
      frame_begin();
      spi_bits(cmd, 8, rx);
      foreach (data[j]) begin
         m_regs[a] = data[j];
         exp_q.push_back('{addr: 3'(a), regs: model_vec()});
         spi_bits(data[j], 8, rx);
         a = (a + 1) % NREG;
      end
      frame_end();
      end_check();
   endtask

   task automatic read_frame(input logic [7:0] cmd, input int nbytes);
      logic [7:0] rx;
      int         a;
      a = int'(cmd[2:0]);
      frame_begin();
`ifdef SPI_REG_TARGET_READ_EN
      check("oe_in_frame", {63'd0, miso_oe}, 64'd1);
      spi_bits(cmd, 8, rx);
      check("miso_during_cmd", {56'd0, rx}, 64'd0);
      for (int j = 0; j < nbytes; j++) begin
         spi_bits(8'($urandom), 8, rx);
         check("read_data", {56'd0, rx}, {56'd0, m_regs[(a + j) % NREG]});
      end
      frame_end();
      check("oe_after_frame", {63'd0, miso_oe}, 64'd0);
`else
      spi_bits(cmd, 8, rx);
      for (int j = 0; j < nbytes; j++) begin
         spi_bits(8'($urandom), 8, rx);
         check("miso_tied_low", {56'd0, rx}, 64'd0);
         check("oe_tied_low", {63'd0, miso_oe}, 64'd0);
      end
      frame_end();
`endif
      end_check();
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] rx;
      rst  = 1'b1;
      sclk = 1'b0;
      csn  = 1'b1;
      mosi = 1'b0;
      for (int i = 0; i < NREG; i++) m_regs[i] = RV;
      #30;
      check("reset_regs", regs, model_vec());
      check("reset_stb", {63'd0, wr_stb}, 64'd0);
      check("reset_addr", {61'd0, wr_addr}, 64'd0);
      check("reset_miso", {63'd0, miso}, 64'd0);
      check("reset_oe", {63'd0, miso_oe}, 64'd0);
      #20;
      rst = 1'b0;
      #50;

      q = {8'hA5};
      write_frame(8'h02, q);
      q = {8'h11, 8'h22, 8'h33};
      write_frame(8'h06, q);

      // Preload reg7/reg0, then read across the wrap.
      q = {8'h5A, 8'hC3};
      write_frame(8'h07, q);
      read_frame(8'h87, 2);
      read_frame(8'h83, 1);

      // Abort mid-byte: partial byte must be discarded.
      frame_begin();
      spi_bits(8'h01, 8, rx);
      spi_bits(8'hFF, 5, rx);
      frame_end();
      end_check();
      q = {8'h3C};
      write_frame(8'h01, q);

      // Reset in the middle of a write byte.
      frame_begin();
      spi_bits(8'h02, 8, rx);
      m_regs[2] = 8'h77;
      exp_q.push_back('{addr: 3'd2, regs: model_vec()});
      spi_bits(8'h77, 8, rx);
      spi_bits(8'h55, 4, rx);
      #20;
      rst = 1'b1;
      #10;
      for (int i = 0; i < NREG; i++) m_regs[i] = RV;
      check("midframe_reset_regs", regs, model_vec());
      check("midframe_reset_oe", {63'd0, miso_oe}, 64'd0);
      check("midframe_reset_addr", {61'd0, wr_addr}, 64'd0);
      #10;
      rst = 1'b0;
      #40;
      csn = 1'b1;
      #100;
      end_check();
      q = {8'h9E};
      write_frame(8'h04, q);

      for (int n = 0; n < 20; n++) begin
         logic [7:0] cmd;
         cmd = 8'($urandom) & 8'h7F;
         if ($urandom_range(0, 2) == 0) begin
            read_frame(cmd | 8'h80, int'($urandom_range(1, 3)));
         end else begin
            q = {};
            for (int j = 0; j < int'($urandom_range(1, 4)); j++) q.push_back(8'($urandom));
            write_frame(cmd, q);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
